// File: rtl/vpi_call_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : vpi_call_sched_if
//  Brief    : Requester, VPI-call and response signal bundle for vpi_call_sched.
//  Revision : 1.0
// ============================================================================
interface vpi_call_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 16,
    parameter int B_W     = 7,
    parameter int C_W     = 32,
    parameter int R_W     = 32
);
    localparam int c_id_w = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ*C_W-1:0] req_c;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   call_valid;
    logic [A_W-1:0]         call_a;
    logic [B_W-1:0]         call_b;
    logic [C_W-1:0]         call_c;
    logic [c_id_w-1:0]      call_id;
    logic                   res_valid;
    logic [R_W-1:0]         res_data;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [R_W-1:0]         rsp_data;
    logic                   rsp_err;
    logic                   busy;

    // Environment side: requesters and the VPI wrapper.
    modport master (
        output req_valid, req_a, req_b, req_c, res_valid, res_data,
        input  req_ready, call_valid, call_a, call_b, call_c, call_id,
               rsp_valid, rsp_data, rsp_err, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_c, res_valid, res_data,
        output req_ready, call_valid, call_a, call_b, call_c, call_id,
               rsp_valid, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/vpi_call_sched.sv
`default_nettype none
// ============================================================================
//  Module   : vpi_call_sched
//  Brief    : Round-robin scheduler sharing one VPI call port among requesters,
//             one call outstanding, with timeout error response.
//  Revision : 1.0
// ============================================================================
module vpi_call_sched #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 16,
    parameter int B_W     = 7,
    parameter int C_W     = 32,
    parameter int R_W     = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vpi_call_sched_if.slave bus
);
    localparam int          c_id_w       = $clog2(NUM_REQ);
    localparam logic [15:0] c_timer_last = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_timer_max  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_id_w-1:0]  r_id;
    logic [A_W-1:0]     r_a;
    logic [B_W-1:0]     r_b;
    logic [C_W-1:0]     r_c;
    logic [R_W-1:0]     r_data;
    logic               r_err;
    logic [15:0]        r_timer;

    logic               w_found;
    logic [c_id_w-1:0]  w_grant_id;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_call_valid;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic [R_W-1:0]     w_rsp_data;
    logic               w_rsp_err;

    // Round-robin search: first pass from rr_ptr upward, second pass wraps from 0.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i] && (i >= int'(r_rr_ptr))) begin
                w_found    = 1'b1;
                w_grant_id = c_id_w'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i]) begin
                w_found    = 1'b1;
                w_grant_id = c_id_w'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = rst_n && (r_state == ST_IDLE) && w_found &&
                         (w_grant_id == c_id_w'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_call_valid = 1'b0;
        w_rsp_valid  = '0;
        w_rsp_data   = '0;
        w_rsp_err    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_call_valid = 1'b1;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.res_valid || (r_timer == c_timer_last)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_rsp_valid[i] = (r_id == c_id_w'(i));
                end
                w_rsp_data  = r_data;
                w_rsp_err   = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_id     <= w_grant_id;
                        r_rr_ptr <= (w_grant_id == c_id_w'(NUM_REQ - 1)) ? '0
                                                                         : w_grant_id + 1'b1;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (w_grant_id == c_id_w'(i)) begin
                                r_a <= bus.req_a[i*A_W +: A_W];
                                r_b <= bus.req_b[i*B_W +: B_W];
                                r_c <= bus.req_c[i*C_W +: C_W];
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    if (bus.res_valid) begin
                        r_data <= bus.res_data;
                        r_err  <= 1'b0;
                    end else if (r_timer == c_timer_last) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else if (r_timer != c_timer_max) begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.call_valid = w_call_valid;
    assign bus.call_a     = r_a;
    assign bus.call_b     = r_b;
    assign bus.call_c     = r_c;
    assign bus.call_id    = r_id;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = w_rsp_data;
    assign bus.rsp_err    = w_rsp_err;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vpi_call_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vpi_call_sched
//  Brief    : Directed self-checking bench for vpi_call_sched (TIMEOUT=8).
//  Revision : 1.0
// ============================================================================
module tb_vpi_call_sched;
    localparam int NUM_REQ = 4;
    localparam int A_W     = 16;
    localparam int B_W     = 7;
    localparam int C_W     = 32;
    localparam int R_W     = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   n;
    int   last_cyc;

    vpi_call_sched_if #(.NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .C_W(C_W), .R_W(R_W)) bus ();

    vpi_call_sched #(
        .NUM_REQ (NUM_REQ),
        .A_W     (A_W),
        .B_W     (B_W),
        .C_W     (C_W),
        .R_W     (R_W),
        .TIMEOUT (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Steps until call_valid is seen, giving up after 20 cycles.
    task automatic wait_call();
        n = 0;
        while (!bus.call_valid && n < 20) begin
            step();
            n++;
        end
        chk("call_seen", 32'(bus.call_valid), 32'd1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        last_cyc = 0;
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        #2 rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        step();
        step();

        // Reset state: outputs quiet even with requests pending
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_call_valid", 32'(bus.call_valid), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_call_id", 32'(bus.call_id), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        step();

        // Single call from requester 0
        bus.req_valid = 4'b0001;
        bus.req_a[15:0] = 16'h1234;
        bus.req_b[6:0] = 7'h55;
        bus.req_c[31:0] = 32'hCAFE0001;
        #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        chk("single_call_valid", 32'(bus.call_valid), 32'd1);
        chk("single_call_a", 32'(bus.call_a), 32'h1234);
        chk("single_call_b", 32'(bus.call_b), 32'h55);
        chk("single_call_c", bus.call_c, 32'hCAFE0001);
        chk("single_call_id", 32'(bus.call_id), 32'd0);
        chk("single_busy", 32'(bus.busy), 32'd1);
        step();
        chk("single_strobe_len", 32'(bus.call_valid), 32'd0);
        step();
        bus.res_valid = 1'b1;
        bus.res_data = 32'h0000_00AA;
        step();
        bus.res_valid = 1'b0;
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("single_rsp_data", bus.rsp_data, 32'hAA);
        chk("single_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("single_call_hold", 32'(bus.call_a), 32'h1234);
        step();
        chk("single_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("single_rsp_data0", bus.rsp_data, 32'd0);
        chk("single_idle", 32'(bus.busy), 32'd0);

        // Reset in IDLE puts the pointer back to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Round-robin with all four requesting, minimum-latency results
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*A_W +: A_W] = 16'hA000 + 16'(i);
        end
        bus.req_valid = 4'b1111;
        #1 chk("rr_ready0", 32'(bus.req_ready), 32'h1);
        step();
        for (int g = 0; g < 5; g++) begin
            wait_call();
            chk("rr_call_id", 32'(bus.call_id), 32'(g % NUM_REQ));
            chk("rr_call_a", 32'(bus.call_a), 32'hA000 + 32'(g % NUM_REQ));
            if (g > 0) begin
                chk("rr_gap", 32'(cyc - last_cyc), 32'd4);
            end
            last_cyc = cyc;
            step();
            bus.res_valid = 1'b1;
            bus.res_data = 32'h100 + 32'(g);
            step();
            bus.res_valid = 1'b0;
            if (g == 4) bus.req_valid = '0;
            chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(1 << (g % NUM_REQ)));
            chk("rr_rsp_data", bus.rsp_data, 32'h100 + 32'(g));
            step();
        end
        step();
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // Stray results in IDLE and ISSUE are dropped; pointer now at 1
        bus.res_valid = 1'b1;
        bus.res_data = 32'hBAD0;
        step();
        chk("stray_idle_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_idle_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 4'b0011;
        #1 chk("stray_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        chk("stray_call_id", 32'(bus.call_id), 32'd1);
        chk("stray_issue", 32'(bus.call_valid), 32'd1);
        step();
        bus.res_valid = 1'b0;
        chk("stray_issue_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("stray_wait_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_wait_busy", 32'(bus.busy), 32'd1);
        bus.res_valid = 1'b1;
        bus.res_data = 32'h600D;
        step();
        bus.res_valid = 1'b0;
        chk("stray_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("stray_rsp_data", bus.rsp_data, 32'h600D);
        step();

        // Timeout on requester 2: response 8 cycles after WAIT entry
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        chk("to_call_id", 32'(bus.call_id), 32'd2);
        n = 0;
        while (bus.rsp_valid == '0 && n < 30) begin
            step();
            n++;
        end
        chk("to_latency", 32'(n), 32'd9);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("to_rsp_data", bus.rsp_data, 32'd0);
        bus.res_valid = 1'b1;
        bus.res_data = 32'h1A7E;
        step();
        chk("to_late_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("to_late_busy", 32'(bus.busy), 32'd0);
        step();
        bus.res_valid = 1'b0;
        chk("to_late_rsp2", 32'(bus.rsp_valid), 32'd0);

        // Reset while waiting drops the call
        bus.req_valid = 4'b1000;
        bus.req_a[3*A_W +: A_W] = 16'h3333;
        step();
        bus.req_valid = '0;
        chk("rw_call_id", 32'(bus.call_id), 32'd3);
        step();
        step();
        rst_n = 1'b0;
        #1 chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_call_a", 32'(bus.call_a), 32'd0);
        step();
        rst_n = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data = 32'hDEAD;
        step();
        bus.res_valid = 1'b0;
        chk("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rw_no_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 4'b1100;
        bus.req_a[2*A_W +: A_W] = 16'h2222;
        #1 chk("rw_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        chk("rw_new_call", 32'(bus.call_valid), 32'd1);
        chk("rw_new_id", 32'(bus.call_id), 32'd2);
        chk("rw_new_a", 32'(bus.call_a), 32'h2222);
        step();
        bus.res_valid = 1'b1;
        bus.res_data = 32'h7777;
        step();
        bus.res_valid = 1'b0;
        chk("rw_new_rsp", 32'(bus.rsp_valid), 32'h4);
        chk("rw_new_data", bus.rsp_data, 32'h7777);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
